// File: rtl/hex_display_scanner.sv
// Four-digit hex scanner for a common-anode 7-segment display.
// A new word is committed only at a frame boundary.
module hex_display_scanner #(
  parameter int unsigned PRESCALE = 50000,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        blank,
  output logic [3:0]  nibble,
  output logic [3:0]  digit_en_n,
  output logic        frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp;
  logic [15:0]   pend;
  logic          pend_v;
  logic          tick;
  logic          wrap;
  logic          lz;
  logic          off;
  logic [3:0]    onehot;

  assign tick = (cnt == CMAX);
  assign wrap = tick && (idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      disp       <= 16'h0000;
      pend       <= 16'h0000;
      pend_v     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (tick) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      // a load landing on the wrap bypasses pend: latest wins
      if (wrap && load) begin
        disp   <= data_in;
        pend_v <= 1'b0;
      end else if (wrap && pend_v) begin
        disp   <= pend;
        pend_v <= 1'b0;
      end else if (load) begin
        pend   <= data_in;
        pend_v <= 1'b1;
      end
    end
  end

  always_comb begin
    nibble = disp[3:0];
    lz     = 1'b0;
    unique case (idx)
      2'd0: begin
        nibble = disp[3:0];
        lz     = 1'b0;
      end
      2'd1: begin
        nibble = disp[7:4];
        lz     = (disp[15:4] == 12'h000);
      end
      2'd2: begin
        nibble = disp[11:8];
        lz     = (disp[15:8] == 8'h00);
      end
      2'd3: begin
        nibble = disp[15:12];
        lz     = (disp[15:12] == 4'h0);
      end
    endcase
  end

  assign onehot     = 4'b0001 << idx;
  assign off        = blank || (LZ_BLANK && lz);
  assign digit_en_n = off ? 4'b1111 : ~onehot;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner, PRESCALE=4.
// u0 shows all digits, u1 blanks leading zeros.
module tb_hex_display_scanner;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic        blank;
  logic [3:0]  nib0;
  logic [3:0]  en0;
  logic        fd0;
  logic [3:0]  nib1;
  logic [3:0]  en1;
  logic        fd1;

  int          vectors;
  int          miscompares;
  int          k;
  logic [15:0] exp_disp;

  hex_display_scanner #(.PRESCALE(4), .LZ_BLANK(1'b0)) u0 (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .blank      (blank),
    .nibble     (nib0),
    .digit_en_n (en0),
    .frame_done (fd0)
  );

  hex_display_scanner #(.PRESCALE(4), .LZ_BLANK(1'b1)) u1 (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .blank      (blank),
    .nibble     (nib1),
    .digit_en_n (en1),
    .frame_done (fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // advance one edge, then check u0 against slot timing and exp_disp
  task automatic step();
    int          ci;
    logic [3:0]  one;
    logic [15:0] sh;
    @(posedge clk);
    #1;
    k++;
    ci  = (k / 4) % 4;
    one = 4'b0001 << ci;
    sh  = exp_disp >> (4 * ci);
    chk("nibble", {12'h000, nib0}, {12'h000, sh[3:0]});
    chk("digit_en_n", {12'h000, en0},
        {12'h000, (blank ? 4'b1111 : ~one)});
    chk("frame_done", {15'h0000, fd0},
        {15'h0000, ((k % 16) == 0)});
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic chk_lz(input logic [3:0] n, input logic [3:0] e);
    chk("lz_nibble", {12'h000, nib1}, {12'h000, n});
    chk("lz_digit_en_n", {12'h000, en1}, {12'h000, e});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    k           = 0;
    exp_disp    = 16'h0000;
    rst         = 1'b1;
    load        = 1'b0;
    data_in     = 16'h0000;
    blank       = 1'b1;

    // reset values
    #2;
    chk("rst_en_blank", {12'h000, en0}, 16'h000F);
    blank = 1'b0;
    #1;
    chk("rst_nibble", {12'h000, nib0}, 16'h0000);
    chk("rst_en", {12'h000, en0}, 16'h000E);
    chk("rst_fd", {15'h0000, fd0}, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // idle scan, then load mid-frame at idx=1
    run_to(36);
    load    = 1'b1;
    data_in = 16'hA5C3;
    step();
    load = 1'b0;
    run_to(47);
    exp_disp = 16'hA5C3;
    run_to(65);

    // double load before wrap: last one wins
    load    = 1'b1;
    data_in = 16'h1234;
    step();
    load = 1'b0;
    run_to(69);
    load    = 1'b1;
    data_in = 16'hBEEF;
    step();
    load = 1'b0;
    run_to(79);
    exp_disp = 16'hBEEF;
    run_to(89);
    load    = 1'b1;
    data_in = 16'h1234;
    step();
    load = 1'b0;
    run_to(95);

    // load on the wrap commits directly and drops the pending word
    load     = 1'b1;
    data_in  = 16'h0F0F;
    exp_disp = 16'h0F0F;
    step();
    load = 1'b0;
    chk_lz(4'hF, 4'b1110);
    run_to(100);
    chk_lz(4'h0, 4'b1101);
    run_to(104);
    chk_lz(4'hF, 4'b1011);
    run_to(108);
    chk_lz(4'h0, 4'b1111);
    run_to(129);

    // leading-zero blanking
    load    = 1'b1;
    data_in = 16'h0040;
    step();
    load = 1'b0;
    run_to(143);
    exp_disp = 16'h0040;
    run_to(144);
    chk_lz(4'h0, 4'b1110);
    run_to(148);
    chk_lz(4'h4, 4'b1101);
    run_to(152);
    chk_lz(4'h0, 4'b1111);
    run_to(156);
    chk_lz(4'h0, 4'b1111);
    run_to(157);
    load    = 1'b1;
    data_in = 16'h0000;
    step();
    load = 1'b0;
    run_to(159);
    exp_disp = 16'h0000;
    run_to(160);
    chk_lz(4'h0, 4'b1110);
    run_to(164);
    chk_lz(4'h0, 4'b1111);
    run_to(168);
    chk_lz(4'h0, 4'b1111);
    run_to(172);
    chk_lz(4'h0, 4'b1111);
    run_to(176);

    // blank for a full frame, release mid-slot
    blank = 1'b1;
    run_to(177);
    load    = 1'b1;
    data_in = 16'hFFFF;
    step();
    load = 1'b0;
    run_to(191);
    exp_disp = 16'hFFFF;
    run_to(194);
    blank = 1'b0;
    run_to(201);

    // async reset with a pending word
    load    = 1'b1;
    data_in = 16'h1234;
    step();
    load = 1'b0;
    run_to(203);
    #2;
    rst = 1'b1;
    #1;
    chk("async_nibble", {12'h000, nib0}, 16'h0000);
    chk("async_en", {12'h000, en0}, 16'h000E);
    chk("async_fd", {15'h0000, fd0}, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    k        = 0;
    exp_disp = 16'h0000;
    run_to(40);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
